// File: rtl/regfile_nport.sv
// N-entry register file: one write port, RD_PORTS combinational read ports.
// Hardwired zero register, optional write-to-read bypass, synchronous clear.
module regfile_nport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [RD_PORTS*AW-1:0]    rd_addr,
  output logic [RD_PORTS*WIDTH-1:0] rd_data,
  output logic                      wr_ack
);

  localparam int LEAVES = 1 << AW;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ack;

  logic w_wr_zero;
  logic w_wr_oor;
  logic w_wr_ok;

  assign w_wr_zero = (32'(wr_addr) == ZERO_REG);
  assign w_wr_oor  = (32'(wr_addr) >= DEPTH);
  assign w_wr_ok   = wr_en && !w_wr_zero && !w_wr_oor;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_wr_ok;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_ok && (wr_addr == AW'(i))) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  assign wr_ack = r_ack;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [AW-1:0]    w_a;
    logic [WIDTH-1:0] w_node [NODES];
    logic             w_inv;
    logic             w_byp;

    assign w_a = rd_addr[p*AW +: AW];

    // Heap-ordered tree: node n has children 2n+1 / 2n+2, leaves at LEAVES-1.
    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
      if (k < DEPTH) begin : g_mem
        assign w_node[LEAVES-1+k] = r_mem[k];
      end else begin : g_pad
        assign w_node[LEAVES-1+k] = '0;
      end
    end

    // Depth d steers on address bit AW-1-d, so the root sees the MSB.
    for (genvar d = 0; d < AW; d++) begin : g_lvl
      for (genvar k = 0; k < (1 << d); k++) begin : g_mux
        localparam int N = (1 << d) - 1 + k;
        localparam int C = 2 * N + 1;
        assign w_node[N] = w_a[AW-1-d] ? w_node[C+1] : w_node[C];
      end
    end

    assign w_inv = (32'(w_a) == ZERO_REG) || (32'(w_a) >= DEPTH);

    if (BYPASS != 0) begin : g_byp
      assign w_byp = wr_en && (w_a == wr_addr);
    end else begin : g_nobyp
      assign w_byp = 1'b0;
    end

    assign rd_data[p*WIDTH +: WIDTH] =
      (reset || w_inv) ? '0 :
      w_byp            ? wr_data :
                         w_node[0];
  end

endmodule

// File: tb/tb_regfile_nport.sv
// Scoreboard bench for regfile_nport: bypass, no-bypass and DEPTH=24 builds
// share one stimulus stream and are checked against an array-based model.
module tb_regfile_nport;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [63:0]  wr_data = '0;
  logic [14:0]  rd_addr = '0;
  logic [127:0] rd_a;
  logic [127:0] rd_b;
  logic [47:0]  rd_c;
  logic         ack_a;
  logic         ack_b;
  logic         ack_c;

  always #5 clk = ~clk;

  regfile_nport #(
    .WIDTH(64), .DEPTH(32), .RD_PORTS(2), .ZERO_REG(31), .BYPASS(1)
  ) u_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr[9:0]), .rd_data(rd_a),
    .wr_ack(ack_a)
  );

  regfile_nport #(
    .WIDTH(64), .DEPTH(32), .RD_PORTS(2), .ZERO_REG(31), .BYPASS(0)
  ) u_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr[9:0]), .rd_data(rd_b),
    .wr_ack(ack_b)
  );

  regfile_nport #(
    .WIDTH(16), .DEPTH(24), .RD_PORTS(3), .ZERO_REG(31), .BYPASS(1)
  ) u_c (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data[15:0]), .rd_addr(rd_addr), .rd_data(rd_c),
    .wr_ack(ack_c)
  );

  typedef struct {
    logic [127:0] ea;
    logic [127:0] eb;
    logic [47:0]  ec;
    logic         ack64;
    logic         ack16;
  } item_t;

  item_t q[$];

  logic [63:0] m64 [32];
  logic [15:0] m16 [24];
  bit          commit64 = 1'b0;
  bit          commit16 = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Expected read for the 32-deep builds, before the coming edge.
  function automatic logic [63:0] ref64(input int a, input bit byp);
    if (reset) return '0;
    if (a == 31 || a >= 32) return '0;
    if (byp && wr_en && a == int'(wr_addr)) return wr_data;
    return m64[a];
  endfunction

  function automatic logic [15:0] ref16(input int a);
    if (reset) return '0;
    if (a == 31 || a >= 24) return '0;
    if (wr_en && a == int'(wr_addr)) return wr_data[15:0];
    return m16[a];
  endfunction

  task automatic step(input bit rst, input bit we, input int wa,
                      input logic [63:0] wd, input int r0, input int r1,
                      input int r2);
    item_t it;
    int ra[3];
    ra = '{r0, r1, r2};
    reset   = rst;
    wr_en   = we;
    wr_addr = wa[4:0];
    wr_data = wd;
    rd_addr = {r2[4:0], r1[4:0], r0[4:0]};
    for (int p = 0; p < 2; p++) begin
      it.ea[p*64 +: 64] = ref64(ra[p], 1'b1);
      it.eb[p*64 +: 64] = ref64(ra[p], 1'b0);
    end
    for (int p = 0; p < 3; p++) begin
      it.ec[p*16 +: 16] = ref16(ra[p]);
    end
    it.ack64 = commit64;
    it.ack16 = commit16;
    q.push_back(it);
    if (rst) begin
      for (int i = 0; i < 32; i++) m64[i] = '0;
      for (int i = 0; i < 24; i++) m16[i] = '0;
      commit64 = 1'b0;
      commit16 = 1'b0;
    end else begin
      commit64 = we && wa != 31;
      commit16 = we && wa != 31 && wa < 24;
      if (commit64) m64[wa] = wd;
      if (commit16) m16[wa] = wd[15:0];
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string nm, input int p,
                              input logic [63:0] got,
                              input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s port%0d: got %h expected %h", nm, p, got, exp);
    end
  endfunction

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        it = q.pop_front();
        for (int p = 0; p < 2; p++) begin
          chk("rd_byp", p, rd_a[p*64 +: 64], it.ea[p*64 +: 64]);
          chk("rd_nobyp", p, rd_b[p*64 +: 64], it.eb[p*64 +: 64]);
        end
        for (int p = 0; p < 3; p++) begin
          chk("rd_d24", p, 64'(rd_c[p*16 +: 16]), 64'(it.ec[p*16 +: 16]));
        end
        chk("ack_byp", 0, 64'(ack_a), 64'(it.ack64));
        chk("ack_nobyp", 0, 64'(ack_b), 64'(it.ack64));
        chk("ack_d24", 0, 64'(ack_c), 64'(it.ack16));
      end
    end
  end

  initial begin : driver
    int a;
    int wa;
    for (int i = 0; i < 32; i++) m64[i] = '0;
    for (int i = 0; i < 24; i++) m16[i] = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 64'hDEAD_BEEF, 5, 5, 5);
    step(1, 0, 0, 0, 5, 5, 5);
    step(0, 0, 0, 0, 5, 5, 5);
    step(0, 1, 3, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
    step(0, 0, 0, 0, 3, 3, 3);
    step(0, 0, 0, 0, 3, 3, 3);
    step(0, 1, 31, '1, 31, 31, 31);
    step(0, 0, 0, 0, 31, 31, 31);
    step(0, 1, 7, 64'h11, 7, 7, 7);
    step(0, 1, 7, 64'h55, 0, 7, 7);
    step(0, 0, 0, 0, 7, 7, 7);
    step(1, 1, 9, 64'hAA, 9, 9, 9);
    step(0, 0, 0, 0, 9, 9, 9);
    step(0, 1, 23, 64'h1234, 23, 23, 23);
    step(0, 1, 27, 64'h4321, 27, 27, 27);
    step(0, 0, 0, 0, 23, 27, 23);
    for (int i = 0; i < 24; i++) begin
      step(0, 1, i, 64'h1111_1111_1111_1111 * 64'(i + 1) ^ 64'(i << 8),
           i, 0, 0);
    end
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, i, i, i);
    end
    for (int n = 0; n < 1500; n++) begin
      wa = int'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, wa,
           {$urandom, $urandom}, a, int'($urandom_range(0, 31)),
           ($urandom_range(0, 1) == 1) ? wa : int'($urandom_range(0, 31)));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
    end
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d items left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_nport.md
Name: regfile_nport

Overview:
- Parametrised register file for the single-cycle datapath. It generalises the 32:1 read-select mux into an N-entry, W-bit storage array with one write port and RD_PORTS independent read ports.
- Includes a hardwired zero register, optional write-to-read bypass, and synchronous clear.
- Sits between instruction decode and the ALU. Reads are combinational, so they fit the single-cycle timing; writes commit on the rising clock edge.

Parameters:
- WIDTH, 64, data width of each register in bits.
- DEPTH, 32, number of registers; any value from 2 to 64.
- RD_PORTS, 2, number of independent read ports; 1 to 4.
- ZERO_REG, 31, index that always reads 0 and ignores writes; set to DEPTH or above to disable.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data; 0 = returns the stored (old) value.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- wr_en  input  1  write enable.
- wr_addr  input  AW  write address.
- wr_data  input  WIDTH  write data.
- rd_addr  input  RD_PORTS*AW  packed read addresses; port p uses bits [p*AW +: AW].
- rd_data  output  RD_PORTS*WIDTH  packed read data; port p uses bits [p*WIDTH +: WIDTH].
- wr_ack  output  1  registered; high for exactly one cycle after a write actually commits.

Behaviour:
- Storage: DEPTH x WIDTH flops, indexed 0..DEPTH-1.
- Reset: at a rising clk edge with reset=1, every register is set to 0 and wr_ack is set to 0. A write presented in the same cycle is dropped. This applies equally to a reset asserted mid-operation.
- rd_data while reset=1: all read ports output 0 combinationally, regardless of address or bypass.
- Write: at a rising edge with reset=0 and wr_en=1, mem[wr_addr] <= wr_data, unless either of the following holds, in which case the write is dropped:
  - wr_addr == ZERO_REG;
  - wr_addr >= DEPTH (only possible when DEPTH is not a power of 2).
- wr_ack: the next-cycle value is 1 only when a write committed this edge. Dropped writes (zero register, out of range, reset) give wr_ack=0.
- Read (combinational, 0-cycle latency), evaluated in this priority order for each port p with address a:
  1. reset=1 -> 0.
  2. a == ZERO_REG or a >= DEPTH -> 0.
  3. BYPASS=1 and wr_en=1 and a == wr_addr -> wr_data, same cycle. Never applies to ZERO_REG or out-of-range addresses, because rule 2 wins.
  4. Otherwise -> mem[a].
- Multiple ports may read the same address in the same cycle; all return identical data.
- Read-after-write with BYPASS=0: the new value is visible from the cycle after the commit edge.
- Read selection is a parametrised mux tree in generate loops, built as a log2 stage structure; no vendor RAM inference.
- No X propagation: every output is defined from the first reset edge onward. Register contents before the first reset are undefined, and the bench does not check them.

Test Plan:
- Reset clear: write 0xDEAD_BEEF to r5, then pulse reset for 1 cycle. Read r5 on port 0 -> 0; wr_ack=0 on the cycle after reset.
- Basic write/read: wr_en=1, wr_addr=3, wr_data=64'h0123_4567_89AB_CDEF for 1 cycle, then read r3 on port 0 and port 1 at once -> both 64'h0123_4567_89AB_CDEF; wr_ack=1 exactly one cycle after the edge.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to r31 -> r31 reads 0 both during the write cycle (bypass suppressed) and after it; wr_ack stays 0.
- Bypass: with BYPASS=1, wr_en=1, wr_addr=7, wr_data=0x55, and port 1 addr=7 in the same cycle -> rd_data port 1 = 0x55 before the edge. Repeat with BYPASS=0 -> the old value before the edge and 0x55 after it.
- Reset mid-write: reset=1 and wr_en=1 to r9 with 0xAA in the same cycle -> r9 reads 0 afterwards; wr_ack=0.
- Non-power-of-2 config: DEPTH=24, WIDTH=16, RD_PORTS=3.
  - Write 0x1234 to r23 -> r23 reads 0x1234.
  - Write to r27 -> dropped; r27 reads 0; wr_ack=0.
  - Sweep all 24 addresses with unique patterns and verify them on all 3 ports.
